// File: rtl/spi_pkg.sv
// spi_pkg: shared frame size, frame type and unpacker FSM states for the SPI frame path.
package spi_pkg;
    localparam int SPI_FRAME_BYTES = 15;
    typedef logic [SPI_FRAME_BYTES*8-1:0] spi_frame_t;
    typedef enum logic [1:0] {IDLE, SEND, CSUM} unpk_state_e;
endpackage

// File: rtl/spi_frame_fifo.sv
// spi_frame_fifo: DEPTH-entry frame FIFO; a push into a full FIFO is accepted only alongside a pop.
module spi_frame_fifo #(
    parameter int WIDTH = 120,
    parameter int DEPTH = 4
) (
    input  logic                         m_clk,
    input  logic                         n_reset,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         push,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic wr_en;
    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign wr_en   = push && (!full || pop);
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge m_clk)
        if (wr_en) mem[wr_ptr] <= wr_data;
    always_ff @(posedge m_clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            level <= level + LW'(wr_en) - LW'(pop);
        end
    end
endmodule

// File: rtl/spi_frame_unpacker.sv
// spi_frame_unpacker: queues parallel SPI frames and replays them as a valid/ready byte stream.
// Define SPI_FRAME_CSUM_EN to append an XOR checksum byte to every frame.
module spi_frame_unpacker
    import spi_pkg::*;
#(
    parameter int FRAME_BYTES = SPI_FRAME_BYTES,
    parameter int DEPTH       = 4
) (
    input  logic                        m_clk,
    input  logic                        n_reset,
    input  logic [FRAME_BYTES*8-1:0]    frame_in,
    input  logic                        frame_valid,
    output logic [7:0]                  byte_out,
    output logic                        byte_valid,
    input  logic                        byte_ready,
    output logic                        byte_last,
    output logic [$clog2(DEPTH+1)-1:0]  level,
    output logic                        overflow,
    input  logic                        clear_ovf
);
    localparam int IW = $clog2(FRAME_BYTES);
    localparam logic [IW-1:0] LAST = IW'(FRAME_BYTES - 1);
`ifdef SPI_FRAME_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    unpk_state_e state;
    logic [IW-1:0] idx, nidx;
    logic [FRAME_BYTES*8-1:0] head;
    logic [7:0] bytes [FRAME_BYTES];
    logic full, empty, pop, drop;
    spi_frame_fifo #(.WIDTH(FRAME_BYTES*8), .DEPTH(DEPTH)) u_fifo (
        .m_clk   (m_clk),
        .n_reset (n_reset),
        .wr_data (frame_in),
        .push    (frame_valid),
        .pop     (pop),
        .rd_data (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );
    always_comb begin
        for (int i = 0; i < FRAME_BYTES; i++) bytes[i] = head[(FRAME_BYTES-1-i)*8 +: 8];
        nidx = idx + IW'(1);
    end
`ifdef SPI_FRAME_CSUM_EN
    logic [7:0] csum;
    always_comb begin
        csum = '0;
        for (int i = 0; i < FRAME_BYTES; i++) csum ^= bytes[i];
    end
    assign pop = byte_ready && state == CSUM;
`else
    assign pop = byte_ready && state == SEND && idx == LAST;
`endif
    // a frame arriving on the same edge as the final pop still finds a free slot
    assign drop = frame_valid && full && !pop;
    always_ff @(posedge m_clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            idx        <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    state      <= SEND;
                    idx        <= '0;
                    byte_out   <= bytes[0];
                    byte_valid <= 1'b1;
                    byte_last  <= 1'b0;
                end
                SEND: if (byte_ready) begin
                    if (idx != LAST) begin
                        idx       <= nidx;
                        byte_out  <= bytes[nidx];
                        byte_last <= !CSUM_EN && nidx == LAST;
                    end else begin
`ifdef SPI_FRAME_CSUM_EN
                        state     <= CSUM;
                        byte_out  <= csum;
                        byte_last <= 1'b1;
`else
                        state      <= IDLE;
                        byte_valid <= 1'b0;
                        byte_last  <= 1'b0;
`endif
                    end
                end
`ifdef SPI_FRAME_CSUM_EN
                CSUM: if (byte_ready) begin
                    state      <= IDLE;
                    byte_valid <= 1'b0;
                    byte_last  <= 1'b0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge m_clk or negedge n_reset) begin
        if (!n_reset) overflow <= 1'b0;
        else overflow <= drop ? 1'b1 : clear_ovf ? 1'b0 : overflow;
    end
endmodule
